pcu_ctrl: RTL and testbench

Program-counter sequencing controller for the multi-cycle npc core. It owns the architectural PC and runs the fetch → decode → resolve loop one instruction at a time: it issues fetch requests to the IFU memory port and hands each fetched instruction to the IDU. It then waits for the IDU branch unit's resolution (`branch_en`/`dnpc`) and computes the next PC. It also absorbs asynchronous-in-time redirects (trap/mret from the CSR unit) at any point in the loop, including while a fetch is outstanding.

---
 rtl/pcu_ctrl_pkg.sv | 24 ++
 rtl/pcu_next_pc.sv | 22 ++
 rtl/pcu_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pcu_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcu_ctrl_pkg.sv
// Shared definitions for the PC sequencing controller: bus widths, reset
// polarity, state encodings and the instruction alignment mask.
package pcu_ctrl_pkg;

  localparam int          INST_ADDR_BUS   = 32;
  localparam logic        RST_ENABLE      = 1'b1;
  localparam logic [31:0] PCU_RESET_PC    = 32'h8000_0000;
  localparam logic [31:0] INST_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    PCU_ST_RESET    = 3'd0,
    PCU_ST_REQ      = 3'd1,
    PCU_ST_WAIT     = 3'd2,
    PCU_ST_DISPATCH = 3'd3,
    PCU_ST_RESOLVE  = 3'd4,
    PCU_ST_HALT     = 3'd5
  } pcu_state_e;

  // Redirect targets are forced word-aligned rather than checked.
  function automatic logic [INST_ADDR_BUS-1:0] align_redirect(input logic [INST_ADDR_BUS-1:0] addr);
    return addr & INST_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pcu_next_pc.sv
// Next-PC selection and alignment check for a resolved instruction.
module pcu_next_pc
  import pcu_ctrl_pkg::*;
(
  input  logic [INST_ADDR_BUS-1:0] pc_i,
  input  logic                     branch_en_i,
  input  logic [INST_ADDR_BUS-1:0] dnpc_i,
  output logic [INST_ADDR_BUS-1:0] npc_o,
  output logic                     misaligned_o
);

  // Bit 0 of a taken target is always dropped (JALR semantics); the
  // sequential path wraps naturally at 2^32.
  always_comb begin
    npc_o = pc_i + 32'd4;
    if (branch_en_i) begin
      npc_o = {dnpc_i[INST_ADDR_BUS-1:1], 1'b0};
    end
    misaligned_o = |(npc_o & ~INST_ALIGN_MASK);
  end

endmodule

// File: rtl/pcu_ctrl.sv
// PC sequencing controller: fetch -> wait -> dispatch -> resolve loop with
// trap/mret redirects and a sticky misaligned-target fault.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   RESET    | first cycle after reset release, loads request register
//   REQ      | fetch request offered, fetch_addr_o held until handshake
//   WAIT     | waiting for fetch response (discarded when kill set)
//   DISPATCH | instruction offered to the IDU
//   RESOLVE  | waiting for branch resolution, computes next PC
//   HALT     | misaligned target seen; only a redirect leaves
module pcu_ctrl
  import pcu_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PCU_RESET_PC,
  parameter int          CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fetch_valid_o,
  input  logic             fetch_ready_i,
  output logic [31:0]      fetch_addr_o,
  input  logic             inst_valid_i,
  output logic             inst_ready_o,
  input  logic [31:0]      inst_i,
  output logic             id_valid_o,
  input  logic             id_ready_i,
  output logic [31:0]      id_pc_o,
  output logic [31:0]      id_inst_o,
  input  logic             resolve_valid_i,
  input  logic             branch_en_i,
  input  logic [31:0]      dnpc_i,
  input  logic             redirect_valid_i,
  input  logic [31:0]      redirect_pc_i,
  output logic             fault_o,
  output logic [31:0]      fault_pc_o,
  output logic [CNT_W-1:0] retired_o
);

  pcu_state_e              state_q, state_d;
  logic [31:0]             pc_q, pc_d;
  logic                    kill_q, kill_d;
  logic [31:0]             req_addr_q, req_addr_d;
  logic [31:0]             id_pc_q, id_pc_d;
  logic [31:0]             id_inst_q, id_inst_d;
  logic                    fault_q, fault_d;
  logic [31:0]             fault_pc_q, fault_pc_d;
  logic [CNT_W-1:0]        retired_q, retired_d;

  logic [31:0]             redir_pc;
  logic [31:0]             npc;
  logic                    npc_misaligned;

  assign redir_pc = align_redirect(redirect_pc_i);

  pcu_next_pc u_next_pc (
    .pc_i         (pc_q),
    .branch_en_i  (branch_en_i),
    .dnpc_i       (dnpc_i),
    .npc_o        (npc),
    .misaligned_o (npc_misaligned)
  );

  // Next-state, PC and bookkeeping; a redirect always wins over other events.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    req_addr_d = req_addr_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    retired_d  = retired_q;

    case (state_q)
      PCU_ST_RESET: begin
        state_d    = PCU_ST_REQ;
        pc_d       = redirect_valid_i ? redir_pc : pc_q;
        req_addr_d = redirect_valid_i ? redir_pc : pc_q;
      end

      PCU_ST_REQ: begin
        // The outstanding request keeps its address; the response it
        // produces is marked for discard instead.
        if (redirect_valid_i) begin
          pc_d   = redir_pc;
          kill_d = 1'b1;
        end
        if (fetch_ready_i) begin
          state_d = PCU_ST_WAIT;
        end
      end

      PCU_ST_WAIT: begin
        if (inst_valid_i) begin
          if (kill_q || redirect_valid_i) begin
            kill_d     = 1'b0;
            state_d    = PCU_ST_REQ;
            pc_d       = redirect_valid_i ? redir_pc : pc_q;
            req_addr_d = redirect_valid_i ? redir_pc : pc_q;
          end else begin
            id_inst_d = inst_i;
            id_pc_d   = pc_q;
            state_d   = PCU_ST_DISPATCH;
          end
        end else if (redirect_valid_i) begin
          pc_d   = redir_pc;
          kill_d = 1'b1;
        end
      end

      PCU_ST_DISPATCH: begin
        if (redirect_valid_i) begin
          pc_d       = redir_pc;
          req_addr_d = redir_pc;
          state_d    = PCU_ST_REQ;
        end else if (id_ready_i) begin
          state_d = PCU_ST_RESOLVE;
        end
      end

      PCU_ST_RESOLVE: begin
        if (redirect_valid_i) begin
          pc_d       = redir_pc;
          req_addr_d = redir_pc;
          state_d    = PCU_ST_REQ;
        end else if (resolve_valid_i) begin
          if (npc_misaligned) begin
            fault_d    = 1'b1;
            fault_pc_d = npc;
            state_d    = PCU_ST_HALT;
          end else begin
            pc_d       = npc;
            req_addr_d = npc;
            retired_d  = retired_q + CNT_W'(1);
            state_d    = PCU_ST_REQ;
          end
        end
      end

      PCU_ST_HALT: begin
        if (redirect_valid_i) begin
          fault_d    = 1'b0;
          pc_d       = redir_pc;
          req_addr_d = redir_pc;
          state_d    = PCU_ST_REQ;
        end
      end

      default: begin
        state_d = PCU_ST_RESET;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= PCU_ST_RESET;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      req_addr_q <= RESET_PC;
      id_pc_q    <= RESET_PC;
      id_inst_q  <= 32'd0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'd0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      req_addr_q <= req_addr_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      retired_q  <= retired_d;
    end
  end

  assign fetch_valid_o = (state_q == PCU_ST_REQ);
  assign inst_ready_o  = (state_q == PCU_ST_WAIT);
  assign id_valid_o    = (state_q == PCU_ST_DISPATCH);
  assign fetch_addr_o  = req_addr_q;
  assign id_pc_o       = id_pc_q;
  assign id_inst_o     = id_inst_q;
  assign fault_o       = fault_q;
  assign fault_pc_o    = fault_pc_q;
  assign retired_o     = retired_q;

endmodule

// File: tb/tb_pcu_ctrl.sv
// Directed bench for pcu_ctrl: peers are driven on the falling edge and
// outputs are sampled on the falling edge.
module tb_pcu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [31:0] fetch_addr_o;
  logic        inst_valid_i;
  logic        inst_ready_o;
  logic [31:0] inst_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        resolve_valid_i;
  logic        branch_en_i;
  logic [31:0] dnpc_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        fault_o;
  logic [31:0] fault_pc_o;
  logic [63:0] retired_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_fetch = 0;
  int t_first = 0;

  pcu_ctrl #(.RESET_PC(32'h8000_0000), .CNT_W(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_valid_o    (fetch_valid_o),
    .fetch_ready_i    (fetch_ready_i),
    .fetch_addr_o     (fetch_addr_o),
    .inst_valid_i     (inst_valid_i),
    .inst_ready_o     (inst_ready_o),
    .inst_i           (inst_i),
    .id_valid_o       (id_valid_o),
    .id_ready_i       (id_ready_i),
    .id_pc_o          (id_pc_o),
    .id_inst_o        (id_inst_o),
    .resolve_valid_i  (resolve_valid_i),
    .branch_en_i      (branch_en_i),
    .dnpc_i           (dnpc_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .fault_o          (fault_o),
    .fault_pc_o       (fault_pc_o),
    .retired_o        (retired_o)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fetch(input string tag, input logic [31:0] addr);
    for (int i = 0; i < 64 && !fetch_valid_o; i++) @(negedge clk);
    chk({tag, "_fvalid"}, 64'(fetch_valid_o), 64'd1);
    chk({tag, "_faddr"}, 64'(fetch_addr_o), 64'(addr));
    last_fetch = cyc;
  endtask

  task automatic fetch_hs();
    fetch_ready_i = 1'b1;
    @(negedge clk);
    fetch_ready_i = 1'b0;
  endtask

  task automatic respond(input logic [31:0] w);
    inst_valid_i = 1'b1;
    inst_i       = w;
    @(negedge clk);
    inst_valid_i = 1'b0;
  endtask

  task automatic dispatch(input string tag, input logic [31:0] pc, input logic [31:0] w);
    chk({tag, "_idvalid"}, 64'(id_valid_o), 64'd1);
    chk({tag, "_idpc"}, 64'(id_pc_o), 64'(pc));
    chk({tag, "_idinst"}, 64'(id_inst_o), 64'(w));
    id_ready_i = 1'b1;
    @(negedge clk);
    id_ready_i = 1'b0;
  endtask

  task automatic resolve(input logic br, input logic [31:0] tgt);
    resolve_valid_i = 1'b1;
    branch_en_i     = br;
    dnpc_i          = tgt;
    @(negedge clk);
    resolve_valid_i = 1'b0;
    branch_en_i     = 1'b0;
  endtask

  task automatic run_inst(input string tag, input logic [31:0] addr, input logic [31:0] w,
                          input logic br, input logic [31:0] tgt);
    wait_fetch(tag, addr);
    fetch_hs();
    respond(w);
    dispatch(tag, addr, w);
    resolve(br, tgt);
  endtask

  initial begin
    rst              = 1'b1;
    fetch_ready_i    = 1'b0;
    inst_valid_i     = 1'b0;
    inst_i           = 32'd0;
    id_ready_i       = 1'b0;
    resolve_valid_i  = 1'b0;
    branch_en_i      = 1'b0;
    dnpc_i           = 32'd0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = 32'd0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_fvalid", 64'(fetch_valid_o), 64'd0);
    chk("rst_iready", 64'(inst_ready_o), 64'd0);
    chk("rst_idvalid", 64'(id_valid_o), 64'd0);
    chk("rst_faddr", 64'(fetch_addr_o), 64'h8000_0000);
    chk("rst_idpc", 64'(id_pc_o), 64'h8000_0000);
    chk("rst_idinst", 64'(id_inst_o), 64'd0);
    chk("rst_fault", 64'(fault_o), 64'd0);
    chk("rst_faultpc", 64'(fault_pc_o), 64'd0);
    chk("rst_retired", retired_o, 64'd0);
    rst = 1'b0;

    // Three not-taken instructions with zero-wait peers
    wait_fetch("boot", 32'h8000_0000);
    t_first = last_fetch;
    run_inst("seq0", 32'h8000_0000, 32'h0000_0013, 1'b0, 32'd0);
    chk("seq0_resolve_to_fetch", 64'(fetch_valid_o), 64'd1);
    run_inst("seq1", 32'h8000_0004, 32'h0010_0093, 1'b0, 32'd0);
    run_inst("seq2", 32'h8000_0008, 32'h0020_0113, 1'b0, 32'd0);
    wait_fetch("seq3", 32'h8000_000C);
    chk("seq_cycles", 64'(last_fetch - t_first), 64'd12);
    chk("seq_retired", retired_o, 64'd3);

    // Taken branch with odd target: bit 0 dropped
    run_inst("br_odd", 32'h8000_000C, 32'h0000_006F, 1'b1, 32'h8000_0101);
    chk("br_odd_fault", 64'(fault_o), 64'd0);
    wait_fetch("br_odd_next", 32'h8000_0100);
    chk("br_odd_retired", retired_o, 64'd4);

    // Misaligned target -> HALT, then redirect recovers
    run_inst("br_mis", 32'h8000_0100, 32'h0000_0067, 1'b1, 32'h8000_0102);
    chk("mis_fault", 64'(fault_o), 64'd1);
    chk("mis_faultpc", 64'(fault_pc_o), 64'h8000_0102);
    repeat (3) @(negedge clk);
    chk("mis_no_fetch", 64'(fetch_valid_o), 64'd0);
    chk("mis_retired", retired_o, 64'd4);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_0200;
    @(negedge clk);
    redirect_valid_i = 1'b0;
    chk("halt_redir_fault", 64'(fault_o), 64'd0);
    wait_fetch("halt_redir", 32'h8000_0200);

    // Redirect in WAIT, response held off 5 cycles and discarded
    fetch_hs();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_0401;
    @(negedge clk);
    redirect_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("wait_kill_iready", 64'(inst_ready_o), 64'd1);
    chk("wait_kill_idvalid_pre", 64'(id_valid_o), 64'd0);
    respond(32'h0000_0013);
    chk("wait_kill_idvalid", 64'(id_valid_o), 64'd0);
    wait_fetch("wait_kill_next", 32'h8000_0400);

    // Redirect in REQ with fetch_ready low for 3 cycles
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_0500;
    @(negedge clk);
    redirect_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("req_kill_fvalid", 64'(fetch_valid_o), 64'd1);
    chk("req_kill_oldaddr", 64'(fetch_addr_o), 64'h8000_0400);
    fetch_hs();
    respond(32'h0000_0013);
    chk("req_kill_idvalid", 64'(id_valid_o), 64'd0);
    wait_fetch("req_kill_next", 32'h8000_0500);

    // Redirect and taken resolve in the same RESOLVE cycle
    fetch_hs();
    respond(32'h0000_0ABC);
    dispatch("res_redir", 32'h8000_0500, 32'h0000_0ABC);
    resolve_valid_i  = 1'b1;
    branch_en_i      = 1'b1;
    dnpc_i           = 32'h8000_0800;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_0600;
    @(negedge clk);
    resolve_valid_i  = 1'b0;
    branch_en_i      = 1'b0;
    redirect_valid_i = 1'b0;
    chk("res_redir_retired", retired_o, 64'd4);
    wait_fetch("res_redir_next", 32'h8000_0600);

    // Redirect on the same cycle as the WAIT response
    fetch_hs();
    inst_valid_i     = 1'b1;
    inst_i           = 32'h0000_0013;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_0700;
    @(negedge clk);
    inst_valid_i     = 1'b0;
    redirect_valid_i = 1'b0;
    chk("wait_same_idvalid", 64'(id_valid_o), 64'd0);
    wait_fetch("wait_same_next", 32'h8000_0700);

    // PC wrap at 2^32
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'hFFFF_FFFC;
    fetch_ready_i    = 1'b1;
    @(negedge clk);
    redirect_valid_i = 1'b0;
    fetch_ready_i    = 1'b0;
    respond(32'h0000_0013);
    run_inst("wrap", 32'hFFFF_FFFC, 32'h0000_0013, 1'b0, 32'd0);
    wait_fetch("wrap_next", 32'h0000_0000);
    chk("wrap_retired", retired_o, 64'd5);

    // Reset mid-operation
    fetch_hs();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_iready", 64'(inst_ready_o), 64'd0);
    chk("mid_rst_faddr", 64'(fetch_addr_o), 64'h8000_0000);
    chk("mid_rst_retired", retired_o, 64'd0);
    rst = 1'b0;
    wait_fetch("mid_rst_boot", 32'h8000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
